// File: rtl/tx_frame_serializer.sv
// Frame sequencer and UART-style serializer: header, WORDS little-endian words, checksum.
// Drives the upstream word mux (selector/data_lock) and prefetches each word during a stop bit.
module tx_frame_serializer #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned WORDS   = 10,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] data_in,
   output logic [7:0]  selector,
   output logic        data_lock,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      LO   = 3'd2,
      HI   = 3'd3,
      CHK  = 3'd4
   } state_t;

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [7:0]  LAST_WORD = 8'(WORDS - 1);

   state_t      state;
   logic [15:0] bit_cyc;
   logic [3:0]  bit_idx;
   logic [7:0]  shift_byte;
   logic [15:0] word_reg;
   logic [7:0]  word_cnt;
   logic [7:0]  csum;
   logic        bit_end;
   logic        prefetch_bit;

   assign state_dbg = state;
   assign bit_end   = (bit_cyc == DIV_LAST);
   // The next word is fetched while the stop bit of HDR, or of a non-last HI byte, is on the line.
   assign prefetch_bit = (bit_idx == 4'd9) &&
                         ((state == HDR) || ((state == HI) && (word_cnt != LAST_WORD)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cyc    <= 16'd0;
         bit_idx    <= 4'd0;
         shift_byte <= 8'd0;
         word_reg   <= 16'd0;
         word_cnt   <= 8'd0;
         csum       <= 8'd0;
         selector   <= 8'd0;
         data_lock  <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            // done gating drops a start that coincides with the end-of-frame pulse.
            if (start && !done) begin
               state      <= HDR;
               busy       <= 1'b1;
               tx         <= 1'b0;
               bit_cyc    <= 16'd0;
               bit_idx    <= 4'd0;
               shift_byte <= HEADER;
               word_cnt   <= 8'd0;
               csum       <= 8'd0;
            end
         end else begin
            if (prefetch_bit) begin
               if (bit_cyc == 16'd0) begin
                  selector  <= (state == HDR) ? word_cnt : word_cnt + 8'd1;
                  data_lock <= 1'b1;
               end
               if (bit_cyc == 16'd1) begin
                  data_lock <= 1'b0;
               end
               if (bit_cyc == 16'd2) begin
                  word_reg <= data_in;
               end
            end

            if (!bit_end) begin
               bit_cyc <= bit_cyc + 16'd1;
            end else begin
               bit_cyc <= 16'd0;
               if (bit_idx != 4'd9) begin
                  bit_idx <= bit_idx + 4'd1;
                  tx      <= (bit_idx == 4'd8) ? 1'b1 : shift_byte[bit_idx[2:0]];
               end else begin
                  bit_idx <= 4'd0;
                  case (state)
                     HDR: begin
                        state      <= LO;
                        shift_byte <= word_reg[7:0];
                        csum       <= csum + word_reg[7:0];
                        tx         <= 1'b0;
                     end
                     LO: begin
                        state      <= HI;
                        shift_byte <= word_reg[15:8];
                        csum       <= csum + word_reg[15:8];
                        tx         <= 1'b0;
                     end
                     HI: begin
                        if (word_cnt == LAST_WORD) begin
                           state      <= CHK;
                           shift_byte <= csum;
                        end else begin
                           state      <= LO;
                           word_cnt   <= word_cnt + 8'd1;
                           shift_byte <= word_reg[7:0];
                           csum       <= csum + word_reg[7:0];
                        end
                        tx <= 1'b0;
                     end
                     CHK: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: vector table of frames against a WORDS=10 instance,
// a line decoder popping an expected-byte queue, and a WORDS=1 instance for the short frame.
module tb_tx_frame_serializer;

   localparam int DIV       = 4;
   localparam int NW        = 10;
   localparam int FRAME_LEN = (2*NW + 2) * 10 * DIV;

   typedef struct {
      int         mode;      // 0: word k = {k,k}, 1: all FFFF, 2: random
      bit         noise;
      bit         restart;
      int         reset_at;
      logic [7:0] exp_chk;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start1 = 1'b0;
   logic [15:0] data_in;
   logic [7:0]  selector, selector1;
   logic        data_lock, data_lock1;
   logic        tx, tx1, busy, busy1, done, done1;
   logic [2:0]  state_dbg, state_dbg1;

   logic [15:0] word_mem [0:255];
   logic [15:0] mux_out = 16'd0;
   logic [15:0] noise = 16'd0;
   logic        mux_valid = 1'b0;
   logic        lock_d = 1'b0;
   logic        noise_en = 1'b0;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp1_q[$];
   int          n_checks = 0;
   int          n_err = 0;

   int          frame_cyc = 0;
   int          lock_idx = 0;
   logic        lock_prev = 1'b0;
   logic        busy_prev = 1'b0;
   logic        rx_act = 1'b0;
   int          rx_cnt = 0;
   logic [9:0]  rx_sh = 10'd0;

   vec_t        vecs [5];

   tx_frame_serializer #(.CLK_DIV(DIV), .WORDS(NW), .HEADER(8'hA5)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .selector(selector), .data_lock(data_lock), .tx(tx), .busy(busy),
      .done(done), .state_dbg(state_dbg)
   );

   tx_frame_serializer #(.CLK_DIV(DIV), .WORDS(1), .HEADER(8'hA5)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .data_in(16'h1234),
      .selector(selector1), .data_lock(data_lock1), .tx(tx1), .busy(busy1),
      .done(done1), .state_dbg(state_dbg1)
   );

   // clock / mux model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      lock_d <= data_lock;
      if (data_lock && !lock_d) begin
         mux_out   <= word_mem[selector];
         mux_valid <= 1'b1;
      end else begin
         mux_valid <= 1'b0;
      end
   end

   always @(negedge clk) noise = 16'($urandom);

   assign data_in = (noise_en && !mux_valid) ? noise : mux_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: handshake timing and line decoder
   always @(negedge clk) begin
      if (!busy) begin
         rx_act    = 1'b0;
         lock_prev = 1'b0;
      end else begin
         if (!busy_prev) begin
            frame_cyc = 0;
            lock_idx  = 0;
         end else begin
            frame_cyc++;
         end
         if (data_lock) begin
            check("lock_width", lock_prev, 1'b0);
            if (!lock_prev) begin
               check("lock_sel", selector, lock_idx);
               check("lock_time", frame_cyc, (20*lock_idx + 9)*DIV + 1);
               lock_idx++;
            end
         end
         lock_prev = data_lock;

         if (!rx_act) begin
            if (tx == 1'b0) begin
               rx_act = 1'b1;
               rx_cnt = 0;
            end
         end else begin
            rx_cnt++;
         end
         if (rx_act && (rx_cnt % DIV) == DIV/2) begin
            rx_sh[rx_cnt/DIV] = tx;
            if (rx_cnt/DIV == 9) begin
               rx_act = 1'b0;
               check("rx_start_bit", rx_sh[0], 1'b0);
               check("rx_stop_bit", rx_sh[9], 1'b1);
               if (exp_q.size() == 0) check("rx_extra_byte", exp_q.size(), 0);
               else check("rx_byte", rx_sh[8:1], exp_q.pop_front());
            end
         end
      end
      busy_prev = busy;
   end

   // driver: one frame on the WORDS=10 instance
   task automatic run_frame(input vec_t v);
      int         cyc;
      int         busy_len;
      int         done_cnt;
      logic [7:0] sum;
      noise_en = v.noise;
      for (int k = 0; k < NW; k++) begin
         case (v.mode)
            0:       word_mem[k] = {8'(k), 8'(k)};
            1:       word_mem[k] = 16'hFFFF;
            default: word_mem[k] = 16'($urandom_range(0, 65535));
         endcase
      end
      sum = 8'd0;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < NW; k++) begin
         exp_q.push_back(word_mem[k][7:0]);
         exp_q.push_back(word_mem[k][15:8]);
         sum = sum + word_mem[k][7:0] + word_mem[k][15:8];
      end
      exp_q.push_back((v.mode == 2) ? sum : v.exp_chk);

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; busy_len = 0; done_cnt = 0;
      while (cyc < FRAME_LEN + 50) begin
         if (busy) busy_len++;
         if (done) begin
            done_cnt++;
            break;
         end
         if (v.restart && cyc == 200) start = 1'b1;
         else if (v.restart && cyc == 201) start = 1'b0;
         if (cyc == v.reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_selector", selector, 8'd0);
            check("rst_data_lock", data_lock, 1'b0);
            check("rst_done", done, 1'b0);
            reset = 1'b0;
            exp_q.delete();
            repeat (3) @(negedge clk);
            check("rst_stays_idle", busy, 1'b0);
            return;
         end
         @(negedge clk);
         cyc++;
      end
      if (v.restart) start = 1'b1;
      @(negedge clk); start = 1'b0;
      if (done) done_cnt++;
      @(negedge clk);
      if (done) done_cnt++;
      check("idle_busy", busy, 1'b0);
      check("idle_tx", tx, 1'b1);
      check("busy_len", busy_len, FRAME_LEN);
      check("done_pulses", done_cnt, 1);
      check("lock_pulses", lock_idx, NW);
      check("bytes_left", exp_q.size(), 0);
   endtask

   // driver: the WORDS=1 instance with data 16'h1234
   task automatic run_words1();
      logic       b1 [160];
      int         cyc, len, locks;
      logic       lp;
      logic [7:0] byte_v;
      exp1_q = {8'hA5, 8'h34, 8'h12, 8'h46};
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      cyc = 0; len = 0; locks = 0; lp = 1'b0;
      while (cyc < 300) begin
         if (done1) break;
         if (busy1) begin
            if (len < 160) b1[len] = tx1;
            len++;
         end
         if (data_lock1 && !lp) begin
            locks++;
            check("w1_selector", selector1, 8'd0);
         end
         lp = data_lock1;
         @(negedge clk);
         cyc++;
      end
      check("w1_len", len, 160);
      check("w1_locks", locks, 1);
      if (len >= 160) begin
         for (int j = 0; j < 4; j++) begin
            for (int b = 1; b <= 8; b++) byte_v[b-1] = b1[j*40 + b*DIV + DIV/2];
            check("w1_start_bit", b1[j*40 + DIV/2], 1'b0);
            check("w1_stop_bit", b1[j*40 + 9*DIV + DIV/2], 1'b1);
            check("w1_byte", byte_v, exp1_q.pop_front());
         end
      end
   endtask

   initial begin
      vecs[0] = '{0, 1'b0, 1'b0, -1,  8'h5A};
      vecs[1] = '{1, 1'b1, 1'b0, -1,  8'hEC};
      vecs[2] = '{0, 1'b1, 1'b1, -1,  8'h5A};
      vecs[3] = '{0, 1'b0, 1'b0, 373, 8'h5A};
      vecs[4] = '{2, 1'b1, 1'b0, -1,  8'h00};
      for (int k = 0; k < 256; k++) word_mem[k] = 16'd0;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_data_lock", data_lock, 1'b0);
      check("reset_selector", selector, 8'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i]);
         repeat (3) @(negedge clk);
      end
      run_words1();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Frame sequencer and UART-style serializer for the transmit path. It drives the word selector and load strobe of the upstream 16-bit word multiplexer, captures each selected word and shifts out a fixed frame on a single line: header byte, WORDS little-endian 16-bit words, then an 8-bit checksum. It sits directly downstream of the word multiplexer and drives the physical tx pin.

## Interface
Parameters:
- CLK_DIV, 16: clk cycles per bit; legal range 4..65535.
- WORDS, 10: words per frame; legal range 1..256.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- start, in, 1: frame request; sampled only in IDLE.
- data_in, in, 16: word from the upstream mux output.
- selector, out, 8: word index to the mux.
- data_lock, out, 1: registered load strobe to the mux; the mux loads on its rising edge.
- tx, out, 1: serial line; idles high.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse at frame end.

## Operation
- Reset values: tx=1, busy=0, done=0, data_lock=0, selector=0. All internal counters are 0 and the state is IDLE.
- States:
  - IDLE -> HDR on start.
  - HDR -> LO -> HI -> (LO for the next word, or CHK after the last word).
  - CHK -> IDLE.
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is CLK_DIV cycles, timed by a 16-bit bit-cycle counter and a 4-bit bit index.
- Frame order:
  - HEADER.
  - For k=0..WORDS-1: data[7:0], then data[15:8] of word k.
  - Checksum.
- Checksum: 8-bit sum, modulo 256, of the 2*WORDS data bytes. The header is excluded.
- Word prefetch happens during the stop bit of HDR, or of HI for a non-last word:
  - Stop-bit cycle 0: selector <= k, data_lock <= 1.
  - Cycle 1: data_lock <= 0.
  - End of cycle 2: capture data_in into the word register.
  - Because CLK_DIV>=4, the capture completes before the stop bit ends. Bytes are back-to-back with no idle gap.
- data_lock is high for exactly one cycle per word, WORDS pulses per frame. selector holds its last value between frames.
- start while busy=1 is ignored and is not queued. start on the same cycle as done is ignored.
- Changes to data_in outside a capture cycle have no effect on the frame.

## Timing
- start high in IDLE at edge E0:
  - busy=1 and tx=0 (header start bit) from E0.
- Frame length: exactly (2*WORDS+2)*10*CLK_DIV cycles from E0 to the end of the checksum stop bit.
- End of frame, at the edge ending the last stop-bit cycle:
  - busy=0 and done=1 for one cycle.
  - tx stays 1.
- Mux handshake latency: data_lock rises, the mux output is valid 1 cycle later, and it is captured at the following edge. Total: 2 cycles from the data_lock rising edge to capture.
- Reset at any cycle, including mid-bit or during a data_lock pulse:
  - On the next edge: tx=1, busy=0, data_lock=0, selector=0, no done pulse.
  - The partial frame is abandoned.
- A new start is accepted the cycle after done; the second frame is back-to-back with the first.

## Test plan
- CLK_DIV=4, WORDS=10, mux word k = {k,k}, one start pulse:
  - Line decodes A5 00 00 01 01 .. 09 09 5A.
  - busy is high for exactly 880 cycles.
  - done pulses once.
  - 10 data_lock pulses, with selector 0..9 in order.
- All words 16'hFFFF, WORDS=10: checksum byte 8'hEC; every data byte FF.
- Per-word handshake timing:
  - Each data_lock pulse is exactly one cycle wide and falls in the stop bit of the preceding byte.
  - data_in is captured 2 cycles after the rising edge.
  - Toggling data_in at all other cycles does not alter the frame.
- start pulsed again mid-frame: ignored; frame length and content unchanged. start on the done cycle is also ignored.
- reset asserted during bit 3 of word 4's low byte:
  - Next edge: tx=1, busy=0, selector=0, data_lock=0.
  - A subsequent start produces a complete, correct frame.
- WORDS=1, CLK_DIV=4, data 16'h1234:
  - Frame is A5 34 12 46.
  - Length 160 cycles.
  - One data_lock pulse, selector=0.
